// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchroniser, start-bit validation at half bit,
// mid-bit data/parity/stop sampling, one-entry output register with overrun flag.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 rx_clk,
    input  logic                 rx_in,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic [2:0]           fsm_state
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state;
    logic [TW-1:0]        tcnt;
    logic [BW-1:0]        bidx;
    logic [DATA_BITS-1:0] shreg;
    logic                 sync1, sync2, prev;
    logic                 p_en, p_odd, par_bad;
    logic                 rx_s;
    logic [TW-1:0]        tcnt_next;

    assign rx_s      = sync2;
    assign rx_busy   = (state != S_IDLE);
    assign fsm_state = state;
    assign tcnt_next = (tcnt == T_LAST) ? '0 : tcnt + T_ONE;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tcnt        <= '0;
            bidx        <= '0;
            shreg       <= '0;
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            prev        <= 1'b1;
            p_en        <= 1'b0;
            p_odd       <= 1'b0;
            par_bad     <= 1'b0;
            rx_data     <= '0;
            rx_ready    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            sync1 <= rx_in;
            sync2 <= sync1;
            // A read clears the flag; a frame completing in the same cycle wins below.
            if (rd_en) rx_ready <= 1'b0;
            if (rx_clk) begin
                prev <= rx_s;
                case (state)
                    S_IDLE: begin
                        if (!rx_s && prev) begin
                            tcnt  <= '0;
                            p_en  <= parity_en;
                            p_odd <= parity_odd;
                            state <= S_START;
                        end
                    end
                    S_START: begin
                        if (tcnt == T_HALF) begin
                            if (rx_s) begin
                                state <= S_IDLE;
                            end else begin
                                tcnt  <= '0;
                                bidx  <= '0;
                                state <= S_DATA;
                            end
                        end else begin
                            tcnt <= tcnt_next;
                        end
                    end
                    S_DATA: begin
                        tcnt <= tcnt_next;
                        if (tcnt == T_LAST) begin
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            bidx  <= bidx + B_ONE;
                            if (bidx == B_LAST) state <= p_en ? S_PARITY : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        tcnt <= tcnt_next;
                        if (tcnt == T_LAST) begin
                            par_bad <= (^shreg) ^ rx_s ^ p_odd;
                            state   <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        tcnt <= tcnt_next;
                        if (tcnt == T_LAST) begin
                            rx_data     <= shreg;
                            frame_err   <= ~rx_s;
                            parity_err  <= p_en & par_bad;
                            overrun_err <= rx_ready & ~rd_en;
                            rx_ready    <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected
// {data, parity_err, frame_err, overrun_err} go into a queue checked by a monitor.
module tb_uart_rx;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_clk = 1'b0;
    logic       rx_in = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_ready, rx_busy, parity_err, frame_err, overrun_err;
    logic [2:0] fsm_state;

    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];
    logic [1:0]  phase = 2'd0;
    logic        mon_prev_busy = 1'b0;
    logic [10:0] mon_exp;

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .rx_clk      (rx_clk),
        .rx_in       (rx_in),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .rd_en       (rd_en),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_busy     (rx_busy),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .fsm_state   (fsm_state)
    );

    always #5 clk_in = ~clk_in;

    // Oversample enable: one clk_in cycle high out of every four.
    initial begin
        forever begin
            @(negedge clk_in);
            rx_clk = (phase == 2'd3);
            phase  = phase + 2'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_in);
            if (mon_prev_busy && !rx_busy && rx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got data 0x%0h, expected no frame", rx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("frame", {21'd0, rx_data, parity_err, frame_err, overrun_err}, {21'd0, mon_exp});
                end
            end
            mon_prev_busy = rx_busy;
        end
    end

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * 64) @(negedge clk_in);
    endtask

    // Start bit begins right after a tick edge; each bit lasts 16 ticks = 64 clocks.
    // With rd_at_done the read strobe lands on the stop-bit mid-sample edge.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop, input logic rd_at_done);
        @(posedge clk_in);
        while (!rx_clk) @(posedge clk_in);
        @(negedge clk_in);
        rx_in = 1'b0;
        repeat (64) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (64) @(negedge clk_in);
        end
        if (pen) begin
            rx_in = pbit;
            repeat (64) @(negedge clk_in);
        end
        rx_in = stop;
        if (rd_at_done) begin
            repeat (35) @(negedge clk_in);
            rd_en = 1'b1;
            @(negedge clk_in);
            rd_en = 1'b0;
            repeat (28) @(negedge clk_in);
        end else begin
            repeat (64) @(negedge clk_in);
        end
    endtask

    task automatic read_byte();
        @(negedge clk_in);
        rd_en = 1'b1;
        @(negedge clk_in);
        rd_en = 1'b0;
        check("ready_cleared", {31'd0, rx_ready}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_data"}, {24'd0, rx_data}, 32'd0);
        check({name, "_flags"}, {27'd0, rx_ready, rx_busy, parity_err, frame_err, overrun_err}, 32'd0);
    endtask

    initial begin
        int seen_busy;
        int budget;

        repeat (3) @(negedge clk_in);
        check_idle_outputs("reset");
        check("reset_state", {29'd0, fsm_state}, 32'd0);
        rst_n = 1'b1;
        idle_bits(2);

        // 0x55 8N1
        exp_q.push_back({8'h55, 3'b000});
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        read_byte();

        // Short low glitch: false start, no byte
        @(posedge clk_in);
        while (!rx_clk) @(posedge clk_in);
        @(negedge clk_in);
        rx_in = 1'b0;
        repeat (20) @(negedge clk_in);
        rx_in = 1'b1;
        seen_busy = 0;
        budget = 0;
        while (budget < 300 && !(seen_busy != 0 && !rx_busy)) begin
            if (rx_busy) seen_busy = 1;
            @(negedge clk_in);
            budget++;
        end
        check("glitch_busy_pulse", seen_busy, 1);
        check("glitch_back_idle", {31'd0, rx_busy}, 32'd0);
        check("glitch_no_ready", {28'd0, rx_ready, parity_err, frame_err, overrun_err}, 32'd0);
        idle_bits(1);

        // 0xA3 even parity with wrong parity bit, then odd parity with correct bit
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        exp_q.push_back({8'hA3, 3'b100});
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0);
        read_byte();
        parity_odd = 1'b1;
        exp_q.push_back({8'hA3, 3'b000});
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0);
        read_byte();
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // Framing error then a 40 bit-time break
        exp_q.push_back({8'h0F, 3'b010});
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        read_byte();
        repeat (40 * 64) @(negedge clk_in);
        check("break_not_busy", {31'd0, rx_busy}, 32'd0);
        check("break_no_ready", {31'd0, rx_ready}, 32'd0);
        idle_bits(2);
        exp_q.push_back({8'h3C, 3'b000});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
        read_byte();

        // Overrun, then a read coinciding with completion
        exp_q.push_back({8'h11, 3'b000});
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back({8'h22, 3'b001});
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back({8'h33, 3'b000});
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b1);
        check("coincident_read_ready", {31'd0, rx_ready}, 32'd0 + 1);
        read_byte();

        // Reset mid-DATA of 0x81; held until the aborted frame has passed
        fork
            send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
            begin
                repeat (250) @(negedge clk_in);
                check("pre_reset_busy", {31'd0, rx_busy}, 32'd1);
                rst_n = 1'b0;
                #1;
                check_idle_outputs("mid_reset");
            end
        join
        @(negedge clk_in);
        rst_n = 1'b1;
        idle_bits(2);
        exp_q.push_back({8'h7E, 3'b000});
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b0);
        read_byte();

        repeat (10) @(negedge clk_in);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
